spi_sram_master: RTL

SPI master that serves the CPU's 16-bit memory port from an external 23LC512-class serial SRAM. Each request is one chip-select frame: an 8-bit opcode, a 16-bit byte address, then two data bytes. A request is a single-cycle `start_read` or `start_write` pulse, and completion is signalled by `busy` falling. The block sits directly below the CPU core and is its only path to program and data memory.

---
 rtl/spi_ram_pkg.sv | 10 +
 rtl/spi_ram_shifter.sv | 71 +++++++
 rtl/spi_sram_master.sv | 116 +++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcodes, frame constants and FSM state type for the serial SRAM master.
package spi_ram_pkg;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_WRMR    = 8'h01;
  localparam logic [7:0] MODE_SEQ   = 8'h40;
  localparam int         FRAME_BITS = 40;

  typedef enum logic [1:0] {IDLE, INIT, SHIFT, END} state_t;
endpackage

// File: rtl/spi_ram_shifter.sv
// Mode-0 bit engine: parallel-load MOSI shift register, MISO capture and
// SCK generation at clk/2, with a slot counter that flags the end of a frame.
module spi_ram_shifter
  import spi_ram_pkg::*;
#(
  parameter int W    = FRAME_BITS,
  parameter int RX_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [W-1:0]    load_frame,
  input  logic [5:0]      load_bits,
  input  logic            run,
  input  logic            miso,
  output logic            mosi,
  output logic            sclk,
  output logic [RX_W-1:0] rx,
  output logic            done
);
  logic [W-1:0]    shreg_q, shreg_d;
  logic [RX_W-1:0] rx_q, rx_d;
  logic [5:0]      slot_q, slot_d;
  logic [5:0]      nbits_q, nbits_d;
  logic            sclk_q, sclk_d;

  // Done once every rising edge has happened and SCK is back low.
  assign done = !sclk_q && (slot_q == nbits_q);
  assign mosi = shreg_q[W-1];
  assign sclk = sclk_q;
  assign rx   = rx_q;

  always_comb begin
    shreg_d = shreg_q;
    rx_d    = rx_q;
    slot_d  = slot_q;
    nbits_d = nbits_q;
    sclk_d  = sclk_q;
    if (load) begin
      shreg_d = load_frame;
      nbits_d = load_bits;
      slot_d  = '0;
      sclk_d  = 1'b0;
    end else if (run && !done) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[RX_W-2:0], miso};
        slot_d = slot_q + 6'd1;
      end else begin
        sclk_d  = 1'b0;
        shreg_d = {shreg_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
      rx_q    <= '0;
      slot_q  <= '0;
      nbits_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      slot_q  <= slot_d;
      nbits_q <= nbits_d;
      sclk_q  <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_sram_master.sv
// CPU memory port to 23LC512-style serial SRAM, one CS frame per request.
// Optional SPI_RAM_MODE_INIT_EN sends a WRMR sequential-mode frame after reset.
module spi_sram_master
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_BITS-1:0]    addr_in,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    start_read,
  input  logic                    start_write,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    busy,
  output logic                    spi_select,
  output logic                    spi_clk,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int FW = 8 + ADDR_BITS + DW;
`ifdef SPI_RAM_MODE_INIT_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t          state_q, state_d;
  logic            is_read_q, is_read_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic            load, run, done;
  logic [FW-1:0]   load_frame;
  logic [5:0]      load_bits;
  logic [DW-1:0]   wr_bytes, rd_word, rx;

  // Wire order is the byte at addr first; each byte goes MSB-first.
  always_comb begin
    wr_bytes = '0;
    rd_word  = '0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      wr_bytes[8*(DATA_BYTES-1-b) +: 8] = data_in[8*b +: 8];
      rd_word[8*b +: 8]                 = rx[8*(DATA_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    data_out_d = data_out_q;
    load       = 1'b0;
    run        = 1'b0;
    load_frame = '0;
    load_bits  = 6'(FW);
    case (state_q)
      IDLE: begin
        if (start_read || start_write) begin
          load       = 1'b1;
          is_read_d  = start_read;
          load_frame = start_read ? {OP_READ, addr_in, {DW{1'b0}}}
                                  : {OP_WRITE, addr_in, wr_bytes};
          state_d    = SHIFT;
        end
      end
`ifdef SPI_RAM_MODE_INIT_EN
      INIT: begin
        load       = 1'b1;
        is_read_d  = 1'b0;
        load_frame = {OP_WRMR, MODE_SEQ, {(FW-16){1'b0}}};
        load_bits  = 6'd16;
        state_d    = SHIFT;
      end
`endif
      SHIFT: begin
        run = 1'b1;
        if (done) state_d = END;
      end
      END: begin
        if (is_read_q) data_out_d = rd_word;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      is_read_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      data_out_q <= data_out_d;
    end
  end

  spi_ram_shifter #(.W(FW), .RX_W(DW)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_frame (load_frame),
    .load_bits  (load_bits),
    .run        (run),
    .miso       (spi_miso),
    .mosi       (spi_mosi),
    .sclk       (spi_clk),
    .rx         (rx),
    .done       (done)
  );

  assign busy       = (state_q != IDLE);
  assign spi_select = (state_q != SHIFT);
  assign data_out   = data_out_q;
endmodule
